// File: rtl/spi_cmd_master.sv
// -----------------------------------------------------------------------------
// spi_cmd_master
// SPI mode-0 initiator for the motor-controller command link. A 16-bit command
// word is shifted out MSB first on MOSI while the responder's 16-bit reply is
// captured from MISO in the same frame.
//
// Ports
//   CLK        system clock, rising edge
//   reset      asynchronous active-high reset
//   cmd_valid  command word available
//   cmd_ready  command can be accepted (IDLE and not in reset)
//   cmd_word   16-bit command, sampled on the accept edge
//   rsp_valid  one-cycle pulse, rsp_word holds the completed frame's reply
//   rsp_word   word received on MISO during the last frame
//   busy       high from the accept edge through the end of the gap
//   SCK        SPI clock, idles low
//   MOSI       serial data to the responder
//   MISO       serial data from the responder
//   SSEL       active-low frame select
// -----------------------------------------------------------------------------
module spi_cmd_master #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int GAP      = 4
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_word,
   output logic        rsp_valid,
   output logic [15:0] rsp_word,
   output logic        busy,
   output logic        SCK,
   output logic        MOSI,
   input  logic        MISO,
   output logic        SSEL
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   localparam int CNT_W = 16;
   // Counters are loaded with N-1 and the phase ends on the cycle they read 0.
   localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(CS_HOLD - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t            state_r, state_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic [4:0]        edge_cnt_r, edge_cnt_s;   // SCK toggles within the frame
   logic [15:0]       tx_shift_r, tx_shift_s;
   logic [15:0]       rx_shift_r, rx_shift_s;
   logic              sck_r, sck_s;
   logic              mosi_r, mosi_s;
   logic              ssel_r, ssel_s;
   logic              busy_r, busy_s;
   logic              rsp_valid_r, rsp_valid_s;
   logic [15:0]       rsp_word_r, rsp_word_s;

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      edge_cnt_s  = edge_cnt_r;
      tx_shift_s  = tx_shift_r;
      rx_shift_s  = rx_shift_r;
      sck_s       = sck_r;
      mosi_s      = mosi_r;
      ssel_s      = ssel_r;
      busy_s      = busy_r;
      rsp_valid_s = 1'b0;
      rsp_word_s  = rsp_word_r;

      case (state_r)
         ST_IDLE: begin
            if (cmd_valid) begin
               state_s    = ST_SETUP;
               cnt_s      = SETUP_LOAD;
               edge_cnt_s = 5'd0;
               // Bit 15 goes straight to MOSI; the register holds the
               // remaining bits pre-shifted so its MSB is always the next bit.
               tx_shift_s = {cmd_word[14:0], 1'b0};
               rx_shift_s = 16'h0000;
               mosi_s     = cmd_word[15];
               ssel_s     = 1'b0;
               busy_s     = 1'b1;
            end else begin
               state_s    = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = ST_SHIFT;
               cnt_s   = DIV_LOAD;
            end else begin
               cnt_s   = cnt_r - CNT_ONE;
            end
         end
         ST_SHIFT: begin
            if (cnt_r == CNT_ZERO) begin
               cnt_s      = DIV_LOAD;
               sck_s      = ~sck_r;
               edge_cnt_s = edge_cnt_r + 5'd1;
               if (!sck_r) begin
                  // Rising toggle: sample MISO as seen at this edge.
                  rx_shift_s = {rx_shift_r[14:0], MISO};
               end else if (edge_cnt_r == 5'd31) begin
                  // 16th falling toggle: MOSI keeps bit 0 through HOLD.
                  state_s    = ST_HOLD;
                  cnt_s      = HOLD_LOAD;
               end else begin
                  mosi_s     = tx_shift_r[15];
                  tx_shift_s = {tx_shift_r[14:0], 1'b0};
               end
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         ST_HOLD: begin
            if (cnt_r == CNT_ZERO) begin
               state_s     = ST_GAP;
               cnt_s       = GAP_LOAD;
               ssel_s      = 1'b1;
               mosi_s      = 1'b0;
               rsp_word_s  = rx_shift_r;
               rsp_valid_s = 1'b1;
            end else begin
               cnt_s = cnt_r - CNT_ONE;
            end
         end
         ST_GAP: begin
            if (cnt_r == CNT_ZERO) begin
               state_s = ST_IDLE;
               busy_s  = 1'b0;
            end else begin
               cnt_s   = cnt_r - CNT_ONE;
            end
         end
         default: begin
            // Illegal encoding: drop back to a quiet bus.
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
            sck_s   = 1'b0;
            mosi_s  = 1'b0;
            ssel_s  = 1'b1;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset forces an idle, deselected bus at once.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         cnt_r       <= CNT_ZERO;
         edge_cnt_r  <= 5'd0;
         tx_shift_r  <= 16'h0000;
         rx_shift_r  <= 16'h0000;
         sck_r       <= 1'b0;
         mosi_r      <= 1'b0;
         ssel_r      <= 1'b1;
         busy_r      <= 1'b0;
         rsp_valid_r <= 1'b0;
         rsp_word_r  <= 16'h0000;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         edge_cnt_r  <= edge_cnt_s;
         tx_shift_r  <= tx_shift_s;
         rx_shift_r  <= rx_shift_s;
         sck_r       <= sck_s;
         mosi_r      <= mosi_s;
         ssel_r      <= ssel_s;
         busy_r      <= busy_s;
         rsp_valid_r <= rsp_valid_s;
         rsp_word_r  <= rsp_word_s;
      end
   end

   assign cmd_ready = (state_r == ST_IDLE) && !reset;
   assign SCK       = sck_r;
   assign MOSI      = mosi_r;
   assign SSEL      = ssel_r;
   assign busy      = busy_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_word  = rsp_word_r;

endmodule

// File: doc/spi_cmd_master.md
Name: spi_cmd_master

Overview:
SPI initiator for the motor-controller command link. It serialises 16-bit command words (opcode [15:13], motor number [3:0], reset/dir/enable bits, divider [12:0]) toward the CPLD's SSP responder. It captures the 16-bit word the responder shifts back on MISO during the same frame. It sits in the host-side/bridge logic between a command source (FIFO or sequencer) and the physical SCK/MOSI/MISO/SSEL pins.

Parameters:
CLK_DIV, 4, SCK half-period in CLK cycles; legal range >=2.
CS_SETUP, 2, CLK cycles from SSEL falling to the start of the first SCK half-period; legal range >=1.
CS_HOLD, 2, CLK cycles from the last SCK falling edge to SSEL rising; legal range >=1.
GAP, 4, minimum CLK cycles SSEL stays high between frames; legal range >=1.

Ports:
CLK  in  1  system clock; all logic is rising-edge.
reset  in  1  asynchronous, active-high reset.
cmd_valid  in  1  command word available.
cmd_ready  out  1  master can accept a command (high only in IDLE).
cmd_word  in  16  command word, sampled on the accept edge.
rsp_valid  out  1  one-cycle pulse: rsp_word holds a completed frame.
rsp_word  out  16  word received on MISO during the last frame, MSB first.
busy  out  1  high from the accept edge through the end of GAP.
SCK  out  1  SPI clock, mode 0 (idles low).
MOSI  out  1  serial data to the responder.
MISO  in  1  serial data from the responder.
SSEL  out  1  active-low frame select.

Behaviour:
- Reset values (asserted asynchronously): SSEL=1, SCK=0, MOSI=0, rsp_valid=0, rsp_word=0, busy=0, state=IDLE, cmd_ready=1.
- All outputs except cmd_ready are registered. cmd_ready = (state==IDLE) && !reset.
- Protocol: SPI mode 0, MSB first, 16 bits per frame.
  - The responder samples MOSI on SCK rising edges; the master samples MISO on SCK rising edges.
  - MOSI changes only while SCK is low.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - Accept when cmd_valid && cmd_ready at an edge (cycle 0).
  - On the accept edge: tx_shift <= cmd_word, MOSI <= cmd_word[15], SSEL <= 0, busy <= 1, go to SETUP.
  - cmd_word is ignored at all other times.
- SETUP:
  - Hold SCK=0 for CS_SETUP cycles.
  - Then enter SHIFT with a half-period counter of CLK_DIV.
- SHIFT:
  - SCK toggles every CLK_DIV cycles, giving 16 rising and 16 falling edges.
  - On each rising toggle: rx_shift <= {rx_shift[14:0], MISO}, using MISO as sampled at that edge.
  - On each falling toggle except the 16th: MOSI <= next bit (bits 14..0 in order).
  - On the 16th falling toggle: go to HOLD.
  - MOSI keeps bit 0 until SSEL rises, then is driven to 0.
- Timing with SSEL falling at cycle 0:
  - First SCK rise at cycle CS_SETUP+CLK_DIV.
  - SCK period is 2*CLK_DIV.
  - Last SCK fall at cycle CS_SETUP+32*CLK_DIV.
- HOLD:
  - SCK=0 and SSEL=0 for CS_HOLD cycles.
  - Then in one edge: SSEL <= 1, rsp_word <= rx_shift, rsp_valid <= 1 (for exactly one cycle), go to GAP.
- GAP:
  - Count GAP cycles with SSEL=1.
  - Then busy <= 0 and return to IDLE; cmd_ready rises in that same cycle.
  - With defaults, a back-to-back frame repeats every 1+2+128+2+4 = 137 cycles.
- Response semantics: the responder loads its reply during the previous frame, so a reply lags its command by one frame. The master does not interpret rsp_word. Issuing a dummy opcode-4 word fetches the pending reply.
- Unknown opcodes are transmitted unchanged; there is no filtering.
- cmd_valid asserted while busy: the command is not accepted and is not lost; the source must hold it until cmd_ready.
- Reset mid-frame:
  - SSEL goes high and SCK goes low immediately (asynchronously).
  - The partial word is discarded and no rsp_valid is issued.
  - After reset deasserts, the block is in IDLE; the next accepted frame starts with fresh shift registers.
- Responder-clock constraint: the SCK half-period (CLK_DIV CLK periods) must be at least 4 periods of the responder's clock, because the responder synchronises SCK. This is an integration rule; the block does not check it.

Test Plan:
- Single frame: cmd_word=0x2ABC, responder model returns 0x4F4B ("OK") -> MOSI rising-edge samples = 0010101010111100; rsp_word=0x4F4B; rsp_valid high exactly 1 cycle, coincident with SSEL rising; SSEL low for 132 cycles (defaults).
- Timing check with defaults -> first SCK rise 6 cycles after SSEL falls; 16 rising edges 8 cycles apart; last fall at cycle 130; SSEL rise at cycle 132; cmd_ready returns at cycle 136.
- Back-to-back: cmd_valid held high with 0x0015 then 0x8000 -> second SSEL fall exactly GAP+1 cycles after the first SSEL rise; SSEL high for >=4 cycles between frames; the responder captures both words in order.
- Hold while busy: pulse a new cmd_word with cmd_valid during SHIFT, then deassert it before IDLE -> no second frame; the first frame's MOSI bits are unchanged.
- Reset mid-SHIFT after the 7th rising edge -> SSEL=1, SCK=0 in the same cycle; rsp_valid never asserts; the next command 0x6001 is transmitted bit-exact.
- MISO tied 1, CLK_DIV=2 build -> rsp_word=0xFFFF; SCK period 4 cycles; the frame completes in 1+2+64+2+4 cycles.
